// File: rtl/digital_clock_pkg.sv
`default_nettype none
// ============================================================================
// Package     : digital_clock_pkg
// Description : Shared time limits and the 12h display mapping used by the
//               parametrised hh:mm:ss timekeeper.
// Revision    : 1.0 - initial release
// ============================================================================
package digital_clock_pkg;

  localparam int SEC_MAX     = 59;
  localparam int MIN_MAX     = 59;
  localparam int HRS_MAX     = 23;
  localparam int HRS_12_NOON = 12;

  // Maps a 24h hour (0..23) to its 12h face value (1..12); midnight and noon show 12.
  function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
    if (h == 5'd0) begin
      return 5'(HRS_12_NOON);
    end else if (h > 5'(HRS_12_NOON)) begin
      return h - 5'(HRS_12_NOON);
    end else begin
      return h;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Modulo-(MAX+1) counter with enable, synchronous load and a
//               carry-out on the MAX -> 0 step. Also exposes the value it will
//               hold after the next edge so the parent can register derived
//               outputs without adding latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic [W-1:0] q_next,
  output logic         carry
);

  // Carry fires only on an enabled step out of the top value.
  assign carry = en && (q == W'(MAX));

  // Next value ignoring reset: load wins over count, count wraps at MAX.
  always_comb begin
    q_next = q;
    if (ld) begin
      q_next = ld_val;
    end else if (en) begin
      q_next = carry ? '0 : q + W'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/digital_clock_param.sv
`default_nettype none
// ============================================================================
// Module      : digital_clock_param
// Description : hh:mm:ss timekeeper with clk-derived seconds prescaler,
//               validated time load, 12h/24h display, alarm match and
//               day-wrap pulse. All outputs registered, single clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module digital_clock_param #(
  parameter int TICKS_PER_SEC = 10,
  parameter int SEC_W         = 6,
  parameter int HRS_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mode_12h,
  input  logic             load,
  input  logic [HRS_W-1:0] ld_hrs,
  input  logic [SEC_W-1:0] ld_min,
  input  logic [SEC_W-1:0] ld_sec,
  input  logic             alarm_en,
  input  logic [HRS_W-1:0] alarm_hrs,
  input  logic [SEC_W-1:0] alarm_min,
  output logic [HRS_W-1:0] hrs,
  output logic [SEC_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             pm,
  output logic             load_err,
  output logic             alarm,
  output logic             day_wrap
);

  import digital_clock_pkg::*;

  localparam int               PRE_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             range_ok;
  logic             load_ok;
  logic             sec_en;
  logic             sec_carry;
  logic             min_carry;
  logic             hrs_carry;
  logic [SEC_W-1:0] sec_next;
  logic [SEC_W-1:0] min_next;
  logic [HRS_W-1:0] hour_q;
  logic [HRS_W-1:0] hour_next;
  logic [HRS_W-1:0] hour_disp_next;

  // Full-width compares so stray upper bits of wide load ports reject the load.
  assign range_ok = (ld_hrs < HRS_W'(HRS_MAX + 1)) &&
                    (ld_min < SEC_W'(MIN_MAX + 1)) &&
                    (ld_sec < SEC_W'(SEC_MAX + 1));
  assign load_ok  = load && range_ok;
  assign tick     = run && (pre_cnt == PRE_LAST);
  // An accepted load swallows a tick landing in the same cycle.
  assign sec_en   = tick && !load_ok;

  // Seconds prescaler: holds while paused, restarts on an accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (load_ok) begin
      pre_cnt <= '0;
    end else if (run) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_en),
    .ld     (load_ok),
    .ld_val (ld_sec),
    .q      (sec),
    .q_next (sec_next),
    .carry  (sec_carry)
  );

  mod_counter #(.W(SEC_W), .MAX(MIN_MAX)) u_min (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_carry),
    .ld     (load_ok),
    .ld_val (ld_min),
    .q      (min),
    .q_next (min_next),
    .carry  (min_carry)
  );

  mod_counter #(.W(HRS_W), .MAX(HRS_MAX)) u_hrs (
    .clk    (clk),
    .rst    (rst),
    .en     (min_carry),
    .ld     (load_ok),
    .ld_val (ld_hrs),
    .q      (hour_q),
    .q_next (hour_next),
    .carry  (hrs_carry)
  );

  // Display mapping works on the upcoming hour so hrs/pm move in step with min/sec.
  assign hour_disp_next = mode_12h ? HRS_W'(hour_to_12h(hour_next[4:0])) : hour_next;

  // Registered display and event pulses; pulses only ever come from tick advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      hrs      <= mode_12h ? HRS_W'(HRS_12_NOON) : '0;
      pm       <= 1'b0;
      load_err <= 1'b0;
      alarm    <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      hrs      <= hour_disp_next;
      pm       <= (hour_next >= HRS_W'(HRS_12_NOON));
      load_err <= load && !range_ok;
      alarm    <= alarm_en && sec_en && (hour_next == alarm_hrs) &&
                  (min_next == alarm_min) && (sec_next == '0);
      day_wrap <= hrs_carry;
    end
  end

  // hour_q is only observed through the display path.
  logic unused_hour_q;
  assign unused_hour_q = ^hour_q;

endmodule
`default_nettype wire

// File: tb/tb_digital_clock_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_digital_clock_param
// Description : Scoreboard bench for digital_clock_param. A seconds-of-day
//               reference model predicts each cycle's outputs into a queue;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digital_clock_param;

  localparam int TPS   = 4;
  localparam int SEC_W = 6;
  localparam int HRS_W = 5;
  localparam int DAY   = 86400;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             mode_12h = 1'b0;
  logic             load = 1'b0;
  logic [HRS_W-1:0] ld_hrs = '0;
  logic [SEC_W-1:0] ld_min = '0;
  logic [SEC_W-1:0] ld_sec = '0;
  logic             alarm_en = 1'b0;
  logic [HRS_W-1:0] alarm_hrs = '0;
  logic [SEC_W-1:0] alarm_min = '0;
  logic [HRS_W-1:0] hrs;
  logic [SEC_W-1:0] min;
  logic [SEC_W-1:0] sec;
  logic             pm;
  logic             load_err;
  logic             alarm;
  logic             day_wrap;

  digital_clock_param #(
    .TICKS_PER_SEC (TPS),
    .SEC_W         (SEC_W),
    .HRS_W         (HRS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mode_12h  (mode_12h),
    .load      (load),
    .ld_hrs    (ld_hrs),
    .ld_min    (ld_min),
    .ld_sec    (ld_sec),
    .alarm_en  (alarm_en),
    .alarm_hrs (alarm_hrs),
    .alarm_min (alarm_min),
    .hrs       (hrs),
    .min       (min),
    .sec       (sec),
    .pm        (pm),
    .load_err  (load_err),
    .alarm     (alarm),
    .day_wrap  (day_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hrs;
    int min;
    int sec;
    int pm;
    int load_err;
    int alarm;
    int day_wrap;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: time as seconds since midnight, prescaler phase as a plain count.
  int m_t   = 0;
  int m_pre = 0;

  // Reference model: evaluates the clock rules on the inputs seen at each rising edge.
  always @(posedge clk) begin
    exp_t e;
    int   h;
    bit   valid;
    bit   tick;
    e.load_err = 0;
    e.alarm    = 0;
    e.day_wrap = 0;
    if (rst) begin
      m_t   = 0;
      m_pre = 0;
    end else begin
      valid = (int'(ld_hrs) < 24) && (int'(ld_min) < 60) && (int'(ld_sec) < 60);
      tick  = run && (m_pre == TPS - 1);
      if (load && valid) begin
        m_t   = int'(ld_hrs) * 3600 + int'(ld_min) * 60 + int'(ld_sec);
        m_pre = 0;
      end else begin
        e.load_err = load ? 1 : 0;
        if (run) m_pre = (m_pre + 1) % TPS;
        if (tick) begin
          m_t        = (m_t + 1) % DAY;
          e.day_wrap = (m_t == 0) ? 1 : 0;
          if (alarm_en && int'(alarm_hrs) < 24 && int'(alarm_min) < 60 &&
              m_t == int'(alarm_hrs) * 3600 + int'(alarm_min) * 60)
            e.alarm = 1;
        end
      end
    end
    h     = m_t / 3600;
    e.min = (m_t / 60) % 60;
    e.sec = m_t % 60;
    e.pm  = (h >= 12) ? 1 : 0;
    if (mode_12h) e.hrs = (h % 12 == 0) ? 12 : h % 12;
    else          e.hrs = h;
    q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp_v);
    checks++;
    if (act !== 32'(exp_v)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare them against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hrs",      32'(hrs),      e.hrs);
      chk("min",      32'(min),      e.min);
      chk("sec",      32'(sec),      e.sec);
      chk("pm",       32'(pm),       e.pm);
      chk("load_err", 32'(load_err), e.load_err);
      chk("alarm",    32'(alarm),    e.alarm);
      chk("day_wrap", 32'(day_wrap), e.day_wrap);
    end
  end

  // Advance n rising edges, then move inputs clear of the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load   = 1'b1;
    ld_hrs = HRS_W'(h);
    ld_min = SEC_W'(m);
    ld_sec = SEC_W'(s);
    step(1);
    load = 1'b0;
  endtask

  initial begin
    int t0;
    int k;
    // Reset, then a full minute of counting.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    run = 1'b1;
    step(244);

    // Day wrap from 23:59:58.
    do_load(23, 59, 58);
    step(10);

    // Rejected loads, then an accepted boundary load.
    do_load(24, 0, 0);
    step(2);
    do_load(10, 60, 0);
    step(2);
    do_load(10, 59, 60);
    step(2);
    do_load(10, 59, 59);
    step(6);

    // 12h display mapping.
    mode_12h = 1'b1;
    do_load(0, 0, 0);
    step(3);
    do_load(12, 30, 0);
    step(3);
    do_load(13, 5, 0);
    step(3);
    mode_12h = 1'b0;
    step(2);

    // Alarm via tick versus via direct load.
    alarm_en  = 1'b1;
    alarm_hrs = 5'd7;
    alarm_min = 6'd0;
    do_load(6, 59, 59);
    step(6);
    do_load(7, 0, 0);
    step(4);

    // Pause mid-second, then reset while a load is requested.
    step(2);
    run = 1'b0;
    step(20);
    run = 1'b1;
    step(6);
    rst    = 1'b1;
    load   = 1'b1;
    ld_hrs = 5'd12;
    ld_min = 6'd34;
    ld_sec = 6'd56;
    step(1);
    rst  = 1'b0;
    load = 1'b0;
    step(4);

    // Randomised traffic around alarm and midnight boundaries.
    for (int i = 0; i < 2000; i++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 149) == 0) begin
        alarm_hrs = HRS_W'($urandom_range(0, 31));
        alarm_min = SEC_W'($urandom_range(0, 63));
      end
      rst  = ($urandom_range(0, 399) == 0);
      load = 1'b0;
      k = $urandom_range(0, 39);
      if (k == 0) begin
        t0 = (int'(alarm_hrs) % 24) * 3600 + (int'(alarm_min) % 60) * 60 - $urandom_range(1, 3);
        t0 = (t0 + DAY) % DAY;
        load   = 1'b1;
        ld_hrs = HRS_W'(t0 / 3600);
        ld_min = SEC_W'((t0 / 60) % 60);
        ld_sec = SEC_W'(t0 % 60);
      end else if (k == 1) begin
        load   = 1'b1;
        ld_hrs = 5'd23;
        ld_min = 6'd59;
        ld_sec = SEC_W'($urandom_range(55, 59));
      end else if (k == 2) begin
        load   = 1'b1;
        ld_hrs = HRS_W'($urandom_range(0, 31));
        ld_min = SEC_W'($urandom_range(0, 63));
        ld_sec = SEC_W'($urandom_range(0, 63));
      end
      step(1);
    end
    rst  = 1'b0;
    load = 1'b0;
    step(3);

    // Bounded drain of any outstanding predictions.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
